leb128_gather: RTL

LEB128_GATHER -- requirements
Module: leb128_gather

---
 rtl/leb128_gather.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/leb128_gather.sv
// leb128_gather: gathers the bytes of one LEB128-encoded value into a fixed
// window so a downstream unsigned unpacker can decode the whole value at once.
// Byte k of a frame lands at m_data[8k +: 8], where m_data[8k] is the
// continuation bit of that byte.
// Optional feature macro: LEB128_GATHER_OVF_EN. When it is defined, an
// over-long value is flagged with m_err and its remaining bytes are drained.
// When it is not defined, an over-long value is cut into separate frames.
module leb128_gather #(
  parameter int N = 64,
  localparam int MB = N / 7 + 1,
  localparam int M = MB * 8,
  localparam int LW = (MB > 1) ? $clog2(MB) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [0:M-1]  m_data,
  output logic [LW-1:0] m_len,
  output logic          m_err,
  output logic          m_valid,
  input  logic          m_ready
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [0:M-1]  win_q, win_d;
  logic [LW-1:0] len_q, len_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;
  logic          rdy_q, rdy_d;
  logic          acc_s;

  // Input acceptance is qualified by the registered ready, which is a pure
  // function of state and therefore has no path from m_ready.
  assign acc_s = s_valid & rdy_q;

  // Next-state logic for the frame collector.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    len_d   = len_q;
    err_d   = err_q;
    valid_d = valid_q;
    case (state_q)
      COLLECT: begin
        if (acc_s) begin
          for (int k = 0; k < MB; k++) begin
            if (cnt_q == LW'(k)) begin
              win_d[8*k +: 8] = s_data;
            end else begin
              win_d[8*k +: 8] = win_q[8*k +: 8];
            end
          end
          if (!s_data[7]) begin
            // Terminator byte: publish the frame on the next edge.
            state_d = HOLD;
            len_d   = cnt_q;
            valid_d = 1'b1;
          end else if (cnt_q == LW'(MB - 1)) begin
            // Window full and the value still continues.
`ifdef LEB128_GATHER_OVF_EN
            state_d = DRAIN;
            len_d   = LW'(MB - 1);
            err_d   = 1'b1;
`else
            state_d = HOLD;
            len_d   = LW'(MB - 1);
            valid_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + LW'(1);
          end
        end else begin
          state_d = COLLECT;
        end
      end
      HOLD: begin
        if (valid_q && m_ready) begin
          // Frame consumed: clear the window so unwritten bytes read as zero.
          state_d = COLLECT;
          valid_d = 1'b0;
          win_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      DRAIN: begin
        // Excess bytes are dropped; the stored window is released at the
        // terminator.
        if (acc_s && !s_data[7]) begin
          state_d = HOLD;
          valid_d = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = COLLECT;
        cnt_d   = '0;
        win_d   = '0;
        len_d   = '0;
        err_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
    rdy_d = (state_d != HOLD);
  end

  // State and output registers; ready stays low for the first cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      win_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      len_q   <= len_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
    end
  end

  assign s_ready = rdy_q;
  assign m_data  = win_q;
  assign m_len   = len_q;
  assign m_err   = err_q;
  assign m_valid = valid_q;

endmodule
